nnrv_trace_buf: RTL and testbench

- Synthesizable retired-instruction trace buffer for the nnrv core; replaces per-cycle simulation printing with on-chip capture.
- Records (pc, instr) of each retired instruction into a circular buffer, stops a configurable number of entries after a PC-match or forced trigger, then drains oldest-first over a valid/ready port.
- Sits beside the fetch/retire path in nnrv_top; readout goes to a debug UART or a bench.

---
 rtl/nnrv_trace_buf.sv | 159 +++++++++++++++
 tb/tb_nnrv_trace_buf.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nnrv_trace_buf.sv
`timescale 1ns/1ps
// nnrv_trace_buf
//   On-chip retired-instruction trace capture for the nnrv core.
//   Records {pc, instr} of every retired instruction into a circular buffer
//   while armed. A PC match or a forced trigger stops capture POST_DEPTH
//   entries later. The buffer then drains oldest-first over a valid/ready port.
//
// Ports
//   i_clk, i_rst         clock, async active-high reset
//   i_valid/i_pc/i_instr retire stream
//   i_arm, i_abort       start capture (IDLE only) / discard and go idle
//   i_trig_en/i_trig_pc  PC-match trigger
//   i_force_trig         trigger on next capture regardless of pc
//   o_rd_valid/i_rd_ready, o_rd_pc/o_rd_instr  readout of oldest entry
//   o_count, o_state, o_wrapped                status
module nnrv_trace_buf #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 64,
  parameter int AW         = 6,
  parameter int POST_DEPTH = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  input  logic            i_arm,
  input  logic            i_abort,
  input  logic            i_trig_en,
  input  logic [XLEN-1:0] i_trig_pc,
  input  logic            i_force_trig,
  output logic            o_rd_valid,
  input  logic            i_rd_ready,
  output logic [XLEN-1:0] o_rd_pc,
  output logic [XLEN-1:0] o_rd_instr,
  output logic [AW:0]     o_count,
  output logic [1:0]      o_state,
  output logic            o_wrapped
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_POST    = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PDEP  = AW'(POST_DEPTH);

  state_t          st, st_n;
  logic [AW-1:0]   wp, wp_n;
  logic [AW:0]     cnt, cnt_n;
  logic [AW-1:0]   pcnt, pcnt_n;
  logic            pend, pend_n;
  logic            wrap, wrap_n;
  logic            we;
  logic            trig;
  logic            acc;
  logic [AW-1:0]   rd_idx;

  logic [2*XLEN-1:0] mem [DEPTH];

  // Pending force and a same-cycle force pulse both count as a trigger.
  assign trig   = i_valid && ((i_trig_en && (i_pc == i_trig_pc)) || pend || i_force_trig);
  assign acc    = (st == S_READOUT) && (cnt != '0) && i_rd_ready;
  // Oldest entry sits count slots behind the write pointer; a full buffer
  // wraps the subtraction back onto wr_ptr itself.
  assign rd_idx = wp - cnt[AW-1:0];

  always_comb begin
    st_n   = st;
    wp_n   = wp;
    cnt_n  = cnt;
    pcnt_n = pcnt;
    pend_n = pend;
    wrap_n = wrap;
    we     = 1'b0;
    if (i_abort) begin
      st_n   = S_IDLE;
      cnt_n  = '0;
      wrap_n = 1'b0;
      pend_n = 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (i_arm) begin
            st_n   = S_ARMED;
            cnt_n  = '0;
            wp_n   = '0;
            wrap_n = 1'b0;
            pend_n = 1'b0;
          end
        end
        S_ARMED, S_POST: begin
          if (st == S_ARMED && i_force_trig) pend_n = 1'b1;
          if (i_valid) begin
            we   = 1'b1;
            wp_n = wp + 1'b1;
            if (cnt == FULL) wrap_n = 1'b1;
            else             cnt_n  = cnt + 1'b1;
            if (st == S_ARMED) begin
              if (trig) begin
                pend_n = 1'b0;
                if (POST_DEPTH == 0) begin
                  st_n = S_READOUT;
                end else begin
                  st_n   = S_POST;
                  pcnt_n = PDEP;
                end
              end
            end else begin
              pcnt_n = pcnt - 1'b1;
              if (pcnt == AW'(1)) st_n = S_READOUT;
            end
          end
        end
        S_READOUT: begin
          if (acc) begin
            cnt_n = cnt - 1'b1;
            if (cnt == (AW+1)'(1)) st_n = S_IDLE;
          end
        end
        default: st_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st   <= S_IDLE;
      wp   <= '0;
      cnt  <= '0;
      pcnt <= '0;
      pend <= 1'b0;
      wrap <= 1'b0;
    end else begin
      st   <= st_n;
      wp   <= wp_n;
      cnt  <= cnt_n;
      pcnt <= pcnt_n;
      pend <= pend_n;
      wrap <= wrap_n;
    end
  end

  // Storage is never cleared; validity is tracked by count alone.
  always_ff @(posedge i_clk) begin
    if (we) mem[wp] <= {i_pc, i_instr};
  end

  assign o_rd_valid = (st == S_READOUT) && (cnt != '0);
  assign o_rd_pc    = mem[rd_idx][2*XLEN-1:XLEN];
  assign o_rd_instr = mem[rd_idx][XLEN-1:0];
  assign o_count    = cnt;
  assign o_state    = st;
  assign o_wrapped  = wrap;

endmodule

// File: tb/tb_nnrv_trace_buf.sv
`timescale 1ns/1ps
module tb_nnrv_trace_buf;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, valid, arm0, arm1, abort, trig_en, force_t, rd_ready;
  logic [31:0] pc, instr, trig_pc;
  logic        rv0, rv1, wr0, wr1;
  logic [31:0] rpc0, rins0, rpc1, rins1;
  logic [6:0]  cnt0, cnt1;
  logic [1:0]  st0, st1;

  ent_t q0[$];
  ent_t q1[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  nnrv_trace_buf #(.XLEN(32), .DEPTH(64), .AW(6), .POST_DEPTH(16)) u0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pc(pc), .i_instr(instr),
    .i_arm(arm0), .i_abort(abort), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
    .i_force_trig(force_t), .o_rd_valid(rv0), .i_rd_ready(rd_ready),
    .o_rd_pc(rpc0), .o_rd_instr(rins0), .o_count(cnt0), .o_state(st0),
    .o_wrapped(wr0));

  nnrv_trace_buf #(.XLEN(32), .DEPTH(64), .AW(6), .POST_DEPTH(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pc(pc), .i_instr(instr),
    .i_arm(arm1), .i_abort(abort), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
    .i_force_trig(force_t), .o_rd_valid(rv1), .i_rd_ready(rd_ready),
    .o_rd_pc(rpc1), .o_rd_instr(rins1), .o_count(cnt1), .o_state(st1),
    .o_wrapped(wr1));

  function automatic logic [31:0] enc(input logic [31:0] p);
    return {16'hC0DE, p[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] p, input bit push0, input bit push1);
    ent_t e;
    valid = 1'b1;
    pc    = p;
    instr = enc(p);
    tick();
    valid = 1'b0;
    e.pc    = p;
    e.instr = enc(p);
    if (push0) q0.push_back(e);
    if (push1) q1.push_back(e);
  endtask

  task automatic drain(input bit toggle, input bit d1);
    int n;
    n = 0;
    rd_ready = 1'b1;
    while (((d1 ? st1 : st0) != 2'd0) && n < 600) begin
      tick();
      n++;
      if (toggle) rd_ready = ~rd_ready;
    end
    rd_ready = 1'b0;
    total++;
    if (n >= 600) begin
      bad++;
      $display("FAIL drain_timeout act=%0d exp=<600", n);
    end
  endtask

  // Scoreboard monitor: any presented entry must match the queue head; it is
  // popped only on accept, so a stalled entry is re-checked each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rv0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL rd0_unexpected act=%h exp=none", rpc0);
        end else begin
          chk("rd0_pc", rpc0, q0[0].pc);
          chk("rd0_instr", rins0, q0[0].instr);
          if (rd_ready) void'(q0.pop_front());
        end
      end
      if (rv1) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL rd1_unexpected act=%h exp=none", rpc1);
        end else begin
          chk("rd1_pc", rpc1, q1[0].pc);
          chk("rd1_instr", rins1, q1[0].instr);
          if (rd_ready) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; arm0 = 1'b0; arm1 = 1'b0; abort = 1'b0;
    trig_en = 1'b0; force_t = 1'b0; rd_ready = 1'b0;
    pc = '0; instr = '0; trig_pc = '0;
    #12;
    chk("rst_state", st0, 2'd0);
    chk("rst_count", cnt0, 7'd0);
    chk("rst_rvalid", rv0, 1'b0);
    chk("rst_wrapped", wr0, 1'b0);
    chk("rst_state1", st1, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: pc match at 0x20, 16 post entries -> 25 entries 0x00..0x60
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    chk("armed_state", st0, 2'd1);
    chk("armed_count", cnt0, 7'd0);
    trig_en = 1'b1; trig_pc = 32'h20;
    for (int i = 0; i < 25; i++) begin
      retire(i * 4, 1'b1, 1'b0);
      if (i == 8) chk("post_entered", st0, 2'd2);
    end
    chk("s1_readout", st0, 2'd3);
    chk("s1_count", cnt0, 7'd25);
    chk("s1_wrapped", wr0, 1'b0);
    retire(32'h999, 1'b0, 1'b0);
    chk("ro_ignores_valid", cnt0, 7'd25);
    drain(1'b0, 1'b0);
    chk("s1_idle_count", cnt0, 7'd0);
    chk("s1_queue_empty", q0.size(), 0);

    // 2: trigger at 0x200 wraps; keeps 0x144..0x240, drained under toggling ready
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    trig_pc = 32'h200;
    for (int i = 0; i < 145; i++) retire(i * 4, (i * 4) >= 32'h144, 1'b0);
    chk("s2_readout", st0, 2'd3);
    chk("s2_count", cnt0, 7'd64);
    chk("s2_wrapped", wr0, 1'b1);
    drain(1'b1, 1'b0);
    chk("s2_queue_empty", q0.size(), 0);
    chk("wrapped_sticky", wr0, 1'b1);

    // 3: force trigger on 3rd retire, POST_DEPTH=0 instance
    trig_en = 1'b0;
    arm1 = 1'b1; tick(); arm1 = 1'b0;
    chk("s3_armed", st1, 2'd1);
    retire(32'h0, 1'b0, 1'b1);
    retire(32'h4, 1'b0, 1'b1);
    chk("s3_no_trig", st1, 2'd1);
    force_t = 1'b1;
    retire(32'h8, 1'b0, 1'b1);
    force_t = 1'b0;
    chk("s3_readout", st1, 2'd3);
    chk("s3_count", cnt1, 7'd3);
    chk("s3_u0_idle", st0, 2'd0);
    drain(1'b0, 1'b1);
    chk("s3_queue_empty", q1.size(), 0);

    // 4: pending force, then abort in POST with valid and arm
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    chk("wrapped_cleared", wr0, 1'b0);
    force_t = 1'b1; tick(); force_t = 1'b0;
    chk("pend_no_trig", st0, 2'd1);
    retire(32'h300, 1'b0, 1'b0);
    chk("pend_post", st0, 2'd2);
    chk("pend_count", cnt0, 7'd1);
    abort = 1'b1; valid = 1'b1; arm0 = 1'b1; pc = 32'h304; instr = enc(32'h304);
    tick();
    abort = 1'b0; valid = 1'b0; arm0 = 1'b0;
    chk("abort_state", st0, 2'd0);
    chk("abort_count", cnt0, 7'd0);
    tick();
    chk("abort_arm_ignored", st0, 2'd0);

    // 5: async reset mid-readout with count=10, then a clean recapture
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    trig_en = 1'b1; trig_pc = 32'h0;
    for (int i = 0; i < 17; i++) retire(i * 4, 1'b1, 1'b0);
    chk("s5_readout", st0, 2'd3);
    chk("s5_count", cnt0, 7'd17);
    rd_ready = 1'b1;
    repeat (7) tick();
    rd_ready = 1'b0;
    chk("s5_count10", cnt0, 7'd10);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_state", st0, 2'd0);
    chk("arst_rvalid", rv0, 1'b0);
    chk("arst_count", cnt0, 7'd0);
    q0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    chk("rearm_state", st0, 2'd1);
    trig_pc = 32'h1000;
    for (int i = 0; i < 17; i++) retire(32'h1000 + i * 4, 1'b1, 1'b0);
    chk("s5b_count", cnt0, 7'd17);
    drain(1'b0, 1'b0);
    chk("s5b_queue_empty", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
